// File: rtl/w0rm_alu_pkg.sv
// W0RM ALU shared definitions: opcodes, flag indices, extend-size encodings.
// Used by the extend pipe and the other ALU units.
package w0rm_alu_pkg;

    localparam logic [3:0] OP_SEX  = 4'hA;
    localparam logic [3:0] OP_ZEX  = 4'hB;
    localparam logic [3:0] OP_BFXS = 4'hC;
    localparam logic [3:0] OP_BFXU = 4'hD;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [1:0] {
        EXT_8    = 2'd0,
        EXT_16   = 2'd1,
        EXT_32   = 2'd2,
        EXT_FULL = 2'd3
    } ext_size_e;

    typedef struct packed {
        logic [3:0] op;
        logic [1:0] size;
    } ext_ctrl_t;

    function automatic int ext_bits(input logic [1:0] sz, input int dw);
        int w;
        unique case (sz)
            EXT_8:   w = 8;
            EXT_16:  w = 16;
            EXT_32:  w = 32;
            default: w = dw;
        endcase
        return (w > dw) ? dw : w;
    endfunction

    function automatic logic is_signed(input logic [3:0] op);
        return (op == OP_SEX) || (op == OP_BFXS);
    endfunction

    function automatic logic is_bfx(input logic [3:0] op);
        return (op == OP_BFXS) || (op == OP_BFXU);
    endfunction

    function automatic logic is_supported(input logic [3:0] op);
        return (op == OP_SEX) || (op == OP_ZEX) || is_bfx(op);
    endfunction

endpackage

// File: rtl/w0rm_pipe_reg.sv
// Valid/ready register slice; accepts when empty or when draining this cycle.
module w0rm_pipe_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;

    assign in_ready_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;

    // Data only moves on a real transfer so bubbles keep the old value.
    always_comb begin
        valid_d = in_ready_o ? in_valid_i : valid_q;
        data_d  = (in_valid_i && in_ready_o) ? in_data_i : data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/w0rm_alu_extend_pipe.sv
// Sign/zero extend and bitfield extract with a 1- or 2-stage
// valid/ready pipeline and full backpressure.
module w0rm_alu_extend_pipe
    import w0rm_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int LATENCY    = 2,
    parameter int OFS_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  data_valid,
    output logic                  data_ready,
    input  logic [3:0]            opcode,
    input  logic [1:0]            ext_size,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic [DATA_WIDTH-1:0] data_b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  result_valid,
    input  logic                  result_ready,
    output logic [3:0]            result_flags
);

    localparam int DW = DATA_WIDTH;

    logic [OFS_WIDTH-1:0] ofs;
    logic [DW-1:0]        field_in;
    ext_ctrl_t            ctrl_in;
    logic [DW+3:0]        out_q;
    logic                 unused_b;

    function automatic logic [DW-1:0] extend(
        input ext_ctrl_t     c,
        input logic [DW-1:0] f
    );
        logic [DW-1:0] r;
        logic          sgn;
        int            w;
        w   = ext_bits(c.size, DW);
        sgn = 1'b0;
        for (int i = 0; i < DW; i++) begin
            if (i == w - 1) sgn = is_signed(c.op) & f[i];
        end
        for (int i = 0; i < DW; i++) begin
            r[i] = (i < w) ? f[i] : sgn;
        end
        if (!is_supported(c.op)) r = '0;
        return r;
    endfunction

    function automatic logic [3:0] flags_of(input logic [DW-1:0] r);
        logic [3:0] fl;
        fl         = '0;
        fl[FLAG_Z] = (r == '0);
        fl[FLAG_N] = r[DW-1];
        return fl;
    endfunction

    assign ctrl_in  = '{op: opcode, size: ext_size};
    assign ofs      = is_bfx(opcode) ? data_b[OFS_WIDTH-1:0] : '0;
    assign field_in = data_a >> ofs;
    assign unused_b = ^data_b[DW-1:OFS_WIDTH];

    generate
        if (LATENCY == 1) begin : g_one
            logic [DW-1:0] res_c;
            logic [DW+3:0] s2_in;

            assign res_c = extend(ctrl_in, field_in);
            assign s2_in = {flags_of(res_c), res_c};

            w0rm_pipe_reg #(.WIDTH(DW + 4)) u_s2 (
                .clk         (clk),
                .reset_n     (reset_n),
                .in_valid_i  (data_valid),
                .in_ready_o  (data_ready),
                .in_data_i   (s2_in),
                .out_valid_o (result_valid),
                .out_ready_i (result_ready),
                .out_data_o  (out_q)
            );
        end else begin : g_two
            logic          s1_valid;
            logic          s1_ready;
            logic [DW+5:0] s1_in;
            logic [DW+5:0] s1_q;
            ext_ctrl_t     s1_ctrl;
            logic [DW-1:0] res_c;
            logic [DW+3:0] s2_in;

            assign s1_in = {ctrl_in, field_in};

            w0rm_pipe_reg #(.WIDTH(DW + 6)) u_s1 (
                .clk         (clk),
                .reset_n     (reset_n),
                .in_valid_i  (data_valid),
                .in_ready_o  (data_ready),
                .in_data_i   (s1_in),
                .out_valid_o (s1_valid),
                .out_ready_i (s1_ready),
                .out_data_o  (s1_q)
            );

            assign s1_ctrl = ext_ctrl_t'(s1_q[DW+5:DW]);
            assign res_c   = extend(s1_ctrl, s1_q[DW-1:0]);
            assign s2_in   = {flags_of(res_c), res_c};

            w0rm_pipe_reg #(.WIDTH(DW + 4)) u_s2 (
                .clk         (clk),
                .reset_n     (reset_n),
                .in_valid_i  (s1_valid),
                .in_ready_o  (s1_ready),
                .in_data_i   (s2_in),
                .out_valid_o (result_valid),
                .out_ready_i (result_ready),
                .out_data_o  (out_q)
            );
        end
    endgenerate

    assign result       = out_q[DW-1:0];
    assign result_flags = out_q[DW+3:DW];

endmodule

// File: tb/tb_w0rm_alu_extend_pipe.sv
// Directed and random checks for the extend pipe: 32-bit/2-stage and
// 16-bit/1-stage instances.
module tb_w0rm_alu_extend_pipe;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic        a_dv, a_dr, a_rv, a_rr;
    logic [3:0]  a_op, a_fl;
    logic [1:0]  a_sz;
    logic [31:0] a_a, a_b, a_res;

    logic        b_dv, b_dr, b_rv, b_rr;
    logic [3:0]  b_op, b_fl;
    logic [1:0]  b_sz;
    logic [15:0] b_a, b_b, b_res;

    w0rm_alu_extend_pipe #(.DATA_WIDTH(32), .LATENCY(2)) u_a (
        .clk(clk), .reset_n(reset_n),
        .data_valid(a_dv), .data_ready(a_dr),
        .opcode(a_op), .ext_size(a_sz),
        .data_a(a_a), .data_b(a_b),
        .result(a_res), .result_valid(a_rv),
        .result_ready(a_rr), .result_flags(a_fl)
    );

    w0rm_alu_extend_pipe #(.DATA_WIDTH(16), .LATENCY(1)) u_b (
        .clk(clk), .reset_n(reset_n),
        .data_valid(b_dv), .data_ready(b_dr),
        .opcode(b_op), .ext_size(b_sz),
        .data_a(b_a), .data_b(b_b),
        .result(b_res), .result_valid(b_rv),
        .result_ready(b_rr), .result_flags(b_fl)
    );

    typedef struct packed {
        logic [3:0]  op;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
    } vec_t;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Independent reference: returns {flags, result}.
    function automatic logic [35:0] model(input logic [3:0] op,
                                          input logic [1:0] sz,
                                          input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int dw);
        logic [31:0] dmask, wmask, f, low, r;
        int ofs, w;
        dmask = (dw == 32) ? 32'hFFFF_FFFF : ((32'd1 << dw) - 1);
        ofs = (op == 4'hC || op == 4'hD) ? int'(b & (dw - 1)) : 0;
        f = (a & dmask) >> ofs;
        w = (sz == 0) ? 8 : (sz == 1) ? 16 : (sz == 2) ? 32 : dw;
        if (w > dw) w = dw;
        wmask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 1);
        low = f & wmask;
        case (op)
            4'hA, 4'hC: r = low[w-1] ? (low | ~wmask) : low;
            4'hB, 4'hD: r = low;
            default:    r = 32'h0;
        endcase
        r = r & dmask;
        return {2'b00, r[dw-1], (r == 32'h0), r};
    endfunction

    vec_t va[12];
    vec_t vb[5];
    logic [35:0] qa[$];
    logic [35:0] qb[$];

    initial begin
        int sent, got, cyc;
        logic saw_nr, stable_ok, have_prev;
        logic [31:0] prev;
        logic pa_stall, pb_stall;
        logic [35:0] pa_val, pb_val;
        int sel;

        va[0]  = '{4'hA, 2'd0, 32'h0000_0080, 32'h0, 32'hFFFF_FF80, 4'h2};
        va[1]  = '{4'hB, 2'd1, 32'h1234_8001, 32'h0, 32'h0000_8001, 4'h0};
        va[2]  = '{4'hC, 2'd0, 32'h0000_F000, 32'd8, 32'hFFFF_FFF0, 4'h2};
        va[3]  = '{4'hD, 2'd0, 32'h0000_F000, 32'd8, 32'h0000_00F0, 4'h0};
        va[4]  = '{4'hC, 2'd1, 32'hFF00_0000, 32'd24, 32'h0000_00FF, 4'h0};
        va[5]  = '{4'h3, 2'd2, 32'hDEAD_BEEF, 32'h0, 32'h0, 4'h1};
        va[6]  = '{4'hA, 2'd3, 32'h8000_0000, 32'h0, 32'h8000_0000, 4'h2};
        va[7]  = '{4'hB, 2'd0, 32'hFFFF_FF00, 32'h0, 32'h0, 4'h1};
        va[8]  = '{4'hA, 2'd2, 32'h7FFF_FFFF, 32'h0, 32'h7FFF_FFFF, 4'h0};
        va[9]  = '{4'hA, 2'd0, 32'h0000_01FF, 32'd4, 32'hFFFF_FFFF, 4'h2};
        va[10] = '{4'hD, 2'd3, 32'h8000_0001, 32'd31, 32'h0000_0001, 4'h0};
        va[11] = '{4'hC, 2'd0, 32'h0000_0400, 32'h23, 32'hFFFF_FF80, 4'h2};

        vb[0] = '{4'hA, 2'd2, 32'h8001, 32'h0, 32'h8001, 4'h2};
        vb[1] = '{4'hB, 2'd0, 32'h80FF, 32'h0, 32'h00FF, 4'h0};
        vb[2] = '{4'hC, 2'd0, 32'hF000, 32'd8, 32'hFFF0, 4'h2};
        vb[3] = '{4'hC, 2'd0, 32'h8000, 32'd12, 32'h0008, 4'h0};
        vb[4] = '{4'hF, 2'd1, 32'hBEEF, 32'h0, 32'h0000, 4'h1};

        reset_n = 1'b0;
        a_dv = 0; a_rr = 1; a_op = 0; a_sz = 0; a_a = 0; a_b = 0;
        b_dv = 0; b_rr = 1; b_op = 0; b_sz = 0; b_a = 0; b_b = 0;
        repeat (2) @(negedge clk);
        chk("rst_a_out", {a_rv, a_fl, a_res}, 37'h0);
        chk("rst_b_out", {b_rv, b_fl, b_res}, 21'h0);
        reset_n = 1'b1;
        #1;
        chk("rst_a_ready", a_dr, 1);
        chk("rst_b_ready", b_dr, 1);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a_dv = 1; a_op = va[i].op; a_sz = va[i].sz;
            a_a = va[i].a; a_b = va[i].b;
            @(negedge clk);
            a_dv = 0;
            chk($sformatf("A%0d_lat1", i), a_rv, 0);
            @(negedge clk);
            chk($sformatf("A%0d_out", i), {a_rv, a_fl, a_res},
                {1'b1, va[i].fl, va[i].res});
        end

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            b_dv = 1; b_op = vb[i].op; b_sz = vb[i].sz;
            b_a = vb[i].a[15:0]; b_b = vb[i].b[15:0];
            @(negedge clk);
            b_dv = 0;
            chk($sformatf("B%0d_out", i), {b_rv, b_fl, b_res},
                {1'b1, vb[i].fl, vb[i].res[15:0]});
        end

        // Backpressure: 4 ops, result_ready low for 3 cycles.
        sent = 0; got = 0; cyc = 0;
        saw_nr = 0; stable_ok = 1; have_prev = 0; prev = 0;
        while (got < 4 && cyc < 30) begin
            @(negedge clk);
            a_rr = !(cyc >= 2 && cyc <= 4);
            a_dv = (sent < 4);
            a_op = 4'hB; a_sz = 2'd3; a_a = 32'(sent + 1); a_b = 0;
            #1;
            if (!a_dr) saw_nr = 1;
            if (have_prev && (a_rv !== 1'b1 || a_res !== prev)) stable_ok = 0;
            have_prev = a_rv && !a_rr;
            prev = a_res;
            if (a_rv && a_rr) begin
                chk($sformatf("bp_res%0d", got), a_res, 32'(got + 1));
                got++;
            end
            if (a_dv && a_dr) sent++;
            cyc++;
        end
        chk("bp_count", got, 4);
        chk("bp_ready_fell", saw_nr, 1);
        chk("bp_stable", stable_ok, 1);
        a_dv = 0; a_rr = 1;
        @(negedge clk);
        chk("bp_no_dup", a_rv, 0);

        // Reset with two ops in flight.
        @(negedge clk);
        a_dv = 1; a_op = 4'hA; a_sz = 0; a_a = 32'h80;
        @(negedge clk);
        a_a = 32'h81;
        @(posedge clk);
        #1;
        chk("rst_pre_rv", a_rv, 1);
        #1;
        a_dv = 0;
        reset_n = 1'b0;
        #1;
        chk("rst_async", {a_rv, a_fl, a_res}, 37'h0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("rst_rel_ready", a_dr, 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("rst_stale%0d", i), a_rv, 0);
        end

        // Random traffic on both instances against the model.
        pa_stall = 0; pb_stall = 0; pa_val = 0; pb_val = 0;
        for (int c = 0; c < 5010; c++) begin
            @(negedge clk);
            if (c < 5000) begin
                a_dv = ($urandom_range(0, 3) != 0);
                a_rr = ($urandom_range(0, 3) != 0);
                sel = $urandom_range(0, 4);
                a_op = (sel == 4) ? 4'($urandom) : 4'(4'hA + sel);
                a_sz = 2'($urandom); a_a = $urandom; a_b = $urandom;
                b_dv = ($urandom_range(0, 3) != 0);
                b_rr = ($urandom_range(0, 2) != 0);
                sel = $urandom_range(0, 4);
                b_op = (sel == 4) ? 4'($urandom) : 4'(4'hA + sel);
                b_sz = 2'($urandom); b_a = 16'($urandom); b_b = 16'($urandom);
            end else begin
                a_dv = 0; a_rr = 1; b_dv = 0; b_rr = 1;
            end
            #1;
            if (pa_stall) chk("A_hold", {a_rv, a_fl, a_res}, {1'b1, pa_val});
            if (pb_stall)
                chk("B_hold", {b_rv, b_fl, b_res}, {1'b1, pb_val[35:32], pb_val[15:0]});
            if (a_rv && a_rr) begin
                if (qa.size() == 0) chk("A_extra", 1, 0);
                else chk("A_rand", {a_fl, a_res}, qa.pop_front());
            end
            if (b_rv && b_rr) begin
                if (qb.size() == 0) chk("B_extra", 1, 0);
                else chk("B_rand", {b_fl, 16'h0, b_res}, qb.pop_front());
            end
            if (a_dv && a_dr) qa.push_back(model(a_op, a_sz, a_a, a_b, 32));
            if (b_dv && b_dr)
                qb.push_back(model(b_op, b_sz, {16'h0, b_a}, {16'h0, b_b}, 16));
            pa_stall = a_rv && !a_rr;
            pa_val = {a_fl, a_res};
            pb_stall = b_rv && !b_rr;
            pb_val = {b_fl, 16'h0, b_res};
        end
        chk("A_drained", qa.size(), 0);
        chk("B_drained", qb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
